// File: rtl/banco_de_registradores_pkg.sv
// processador_pkg: shared constants and types for the 8-bit processor datapath.
//   DATA_WIDTH     - width of a datapath word / register
//   REG_ADDR_WIDTH - width of a register-file address
//   NUM_REGS       - number of general-purpose registers
//   reg_addr_t     - register address type
//   data_t         - datapath word type
package processador_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned REG_ADDR_WIDTH = 3;
  localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

endpackage : processador_pkg

// File: rtl/banco_de_registradores_registrador.sv
// registrador: single storage register with load enable and asynchronous
// active-low clear.
//   clock    - rising-edge clock
//   resetN   - asynchronous active-low clear (dominates load)
//   load     - when high, dadoIn is captured on the rising edge
//   dadoIn   - data to store
//   dadoOut  - current register contents
module registrador
  import processador_pkg::*;
#(
  parameter int unsigned WIDTH = processador_pkg::DATA_WIDTH
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] dadoIn,
  output logic [WIDTH-1:0] dadoOut
);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dadoOut <= '0;
    end else if (load) begin
      dadoOut <= dadoIn;
    end
  end

endmodule : registrador

// File: rtl/banco_de_registradores.sv
// banco_de_registradores: register file with 2**ADDR_WIDTH registers of
// DATA_WIDTH bits, two combinational read ports and one synchronous write
// port. Every register, R0 included, is writable.
//   RegLido1 / RegLido2 - read addresses for ports 1 and 2
//   RegEscr             - write address
//   DadoEscr            - write data
//   Dado1 / Dado2       - read data for ports 1 and 2 (combinational)
//   RegWrite            - write enable, active-high
//   Clock               - rising-edge clock
//   Reset_n             - asynchronous active-low clear of all registers
module banco_de_registradores
#(
  parameter int unsigned DATA_WIDTH = processador_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = processador_pkg::REG_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] RegLido1,
  input  logic [ADDR_WIDTH-1:0] RegLido2,
  input  logic [ADDR_WIDTH-1:0] RegEscr,
  input  logic [DATA_WIDTH-1:0] DadoEscr,
  output logic [DATA_WIDTH-1:0] Dado1,
  output logic [DATA_WIDTH-1:0] Dado2,
  input  logic                  RegWrite,
  input  logic                  Clock,
  input  logic                  Reset_n
);

  import processador_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0]    loadEn;
  logic [DATA_WIDTH-1:0] regs [NumRegs];

  // Write decoder: one-hot load enable, all zero when writes are disabled.
  always_comb begin
    loadEn = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      loadEn[i] = RegWrite && (RegEscr == ADDR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : gRegs
    registrador #(
      .WIDTH (DATA_WIDTH)
    ) uReg (
      .clock   (Clock),
      .resetN  (Reset_n),
      .load    (loadEn[g]),
      .dadoIn  (DadoEscr),
      .dadoOut (regs[g])
    );
  end

  // Read muxes: purely combinational, no bypass from the write port, so a
  // read of the register being written shows the old value until the edge.
  always_comb begin
    Dado1 = regs[RegLido1];
    Dado2 = regs[RegLido2];
  end

endmodule : banco_de_registradores

// File: tb/tb_banco_de_registradores.sv
// tb_banco_de_registradores: self-checking bench for banco_de_registradores.
// Keeps an array model of the eight registers and compares both read ports
// against it through directed and randomized steps.
module tb_banco_de_registradores;

  import processador_pkg::*;

  logic [2:0] RegLido1, RegLido2, RegEscr;
  logic [7:0] DadoEscr, Dado1, Dado2;
  logic       RegWrite, Clock, Reset_n;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  model [8];

  banco_de_registradores #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3)
  ) dut (
    .RegLido1 (RegLido1),
    .RegLido2 (RegLido2),
    .RegEscr  (RegEscr),
    .DadoEscr (DadoEscr),
    .Dado1    (Dado1),
    .Dado2    (Dado2),
    .RegWrite (RegWrite),
    .Clock    (Clock),
    .Reset_n  (Reset_n)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read every register through both ports (port 2 in reverse order).
  // Takes 8 ns, so it fits between a falling and the next rising edge.
  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      RegLido1 = 3'(a);
      RegLido2 = 3'(7 - a);
      #1;
      check($sformatf("%s_p1_r%0d", tag, a), Dado1, model[a]);
      check($sformatf("%s_p2_r%0d", tag, 7 - a), Dado2, model[7 - a]);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  initial begin
    // Reset asserted at time 0, with a write presented that must be ignored.
    Reset_n  = 1'b0;
    RegWrite = 1'b1;
    RegEscr  = 3'd5;
    DadoEscr = 8'hEE;
    RegLido1 = 3'd0;
    RegLido2 = 3'd0;
    clearModel();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    sweep("reset");

    // Release between edges, then fill R[i] = i+1.
    RegWrite = 1'b0;
    Reset_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      RegWrite = 1'b1;
      RegEscr  = 3'(i);
      DadoEscr = 8'(i + 1);
      @(posedge Clock);
      model[i] = 8'(i + 1);
    end
    @(negedge Clock);
    RegWrite = 1'b0;
    sweep("fill");

    // Write disabled: R3 and the rest must hold.
    RegEscr  = 3'd3;
    DadoEscr = 8'hAA;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    sweep("nowrite");

    // Dual port, distinct and shared addresses.
    RegLido1 = 3'd2; RegLido2 = 3'd6; #1;
    check("dual_p1", Dado1, 8'd3);
    check("dual_p2", Dado2, 8'd7);
    RegLido1 = 3'd5; RegLido2 = 3'd5; #1;
    check("same_p1", Dado1, 8'd6);
    check("same_p2", Dado2, 8'd6);

    // Read-during-write: old value before the edge, new after.
    @(negedge Clock);
    RegLido1 = 3'd4;
    RegEscr  = 3'd4;
    DadoEscr = 8'h5C;
    RegWrite = 1'b1;
    #1;
    check("rdw_before", Dado1, 8'd5);
    @(posedge Clock);
    model[4] = 8'h5C;
    #1;
    check("rdw_after", Dado1, 8'h5C);
    @(negedge Clock);
    RegWrite = 1'b0;
    sweep("rdw");

    // Randomized traffic against the array model.
    for (int n = 0; n < 200; n++) begin
      @(negedge Clock);
      RegWrite = 1'($urandom_range(0, 1));
      RegEscr  = 3'($urandom_range(0, 7));
      DadoEscr = 8'($urandom);
      RegLido1 = 3'($urandom_range(0, 7));
      RegLido2 = (n % 5 == 0) ? RegEscr : 3'($urandom_range(0, 7));
      #1;
      check("rnd_pre_p1", Dado1, model[RegLido1]);
      check("rnd_pre_p2", Dado2, model[RegLido2]);
      @(posedge Clock);
      if (RegWrite) model[RegEscr] = DadoEscr;
      #1;
      check("rnd_post_p1", Dado1, model[RegLido1]);
      check("rnd_post_p2", Dado2, model[RegLido2]);
    end
    @(negedge Clock);
    RegWrite = 1'b0;
    sweep("rnd");

    // Async reset pulse between edges clears immediately.
    @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    clearModel();
    #1;
    RegLido1 = 3'd4; RegLido2 = 3'd7; #1;
    check("async_clr_p1", Dado1, 8'h00);
    check("async_clr_p2", Dado2, 8'h00);
    // A write presented while in reset is ignored.
    RegWrite = 1'b1;
    RegEscr  = 3'd2;
    DadoEscr = 8'h77;
    @(posedge Clock);
    @(negedge Clock);
    RegWrite = 1'b0;
    sweep("inreset");
    // First write after release lands.
    Reset_n  = 1'b1;
    RegWrite = 1'b1;
    RegEscr  = 3'd2;
    DadoEscr = 8'h77;
    @(posedge Clock);
    model[2] = 8'h77;
    @(negedge Clock);
    RegWrite = 1'b0;
    sweep("postrel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_banco_de_registradores
